pwm_multi_channel: RTL

//  Parametrised N-channel sign/magnitude PWM motor driver. Replaces the external clock-wizard/divider pair with an internal prescaler.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_channel.sv | 120 ++++++++++++
 rtl/pwm_multi_channel.sv | 89 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM motor driver.
package pwm_pkg;

  // Per-channel update state: normal running, or forced-low dead time before a reversal.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } ch_state_e;

  // Command word layout: MSB is direction, the remaining bits are duty magnitude.
  function automatic int unsigned dir_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

  function automatic int unsigned mag_w(input int unsigned data_w);
    return data_w - 1;
  endfunction

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One motor channel: pending command buffer, active duty/direction, dead-time FSM, registered PWM output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned DEAD_PERIODS = 1,
  parameter int unsigned CNT_W        = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_boundary,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_spd,
  output logic              o_dir,
  output logic              o_busy,
  output logic              o_upd_ack
);

  localparam int unsigned DIR_B = dir_bit(DATA_W);
  localparam int unsigned MAG_W = mag_w(DATA_W);
  localparam int unsigned DC_W  = cnt_w(DEAD_PERIODS);

  logic [DATA_W-1:0] r_pend;
  logic              r_pend_v;
  logic [CNT_W-1:0]  r_duty;
  logic              r_dir;
  logic [DC_W-1:0]   r_dcnt;
  logic              r_spd;
  logic              r_ack;
  ch_state_e         r_state;
  ch_state_e         w_state_nxt;

  logic              w_apply;
  logic              w_enter_dead;
  logic              w_pend_dir;
  logic [MAG_W-1:0]  w_pend_mag;
  logic [CNT_W-1:0]  w_sat_duty;

  assign w_pend_dir = r_pend[DIR_B];
  assign w_pend_mag = r_pend[MAG_W-1:0];
  assign w_sat_duty = (32'(w_pend_mag) >= PERIOD) ? CNT_W'(PERIOD) : CNT_W'(w_pend_mag);

  // Boundary decision: apply the pending command, or start dead time on a reversal of a live output.
  always_comb begin
    w_state_nxt  = r_state;
    w_apply      = 1'b0;
    w_enter_dead = 1'b0;
    if (i_boundary) begin
      case (r_state)
        ST_RUN: begin
          if (r_pend_v) begin
            if ((w_pend_dir == r_dir) || (r_duty == '0)) begin
              w_apply = 1'b1;
            end else begin
              w_enter_dead = 1'b1;
              w_state_nxt  = ST_DEAD;
            end
          end
        end
        ST_DEAD: begin
          if (r_dcnt == DC_W'(1)) begin
            w_apply     = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command buffers, dead-time counter and PWM compare; a write landing on a boundary stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_duty   <= '0;
      r_dir    <= 1'b0;
      r_dcnt   <= '0;
      r_spd    <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_duty   <= w_sat_duty;
        r_dir    <= w_pend_dir;
        r_pend_v <= 1'b0;
      end
      if (w_enter_dead) begin
        r_duty <= '0;
        r_dcnt <= DC_W'(DEAD_PERIODS);
      end else if (i_boundary && (r_state == ST_DEAD) && !w_apply) begin
        r_dcnt <= r_dcnt - 1'b1;
      end
      if (i_wr_en) begin
        r_pend   <= i_wr_data;
        r_pend_v <= 1'b1;
      end
      r_spd <= i_en && (i_cnt < r_duty);
    end
  end

  assign o_spd     = r_spd;
  assign o_dir     = r_dir;
  assign o_upd_ack = r_ack;
  assign o_busy    = r_pend_v | (r_state == ST_DEAD);

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel sign/magnitude PWM driver: shared prescaler and period counter feeding per-channel units.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned DEAD_PERIODS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0]        spd,
  output logic [NUM_CH-1:0]        dir,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        upd_ack,
  output logic                     period_start
);

  localparam int unsigned CNT_W = cnt_w(PERIOD);
  localparam int unsigned PS_W  = cnt_w(PRESCALE);

  logic [PS_W-1:0]  r_pcnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en_q;
  logic             r_period_start;
  logic             w_tick;
  logic             w_wrap;
  logic             w_boundary;

  assign w_tick     = en && (r_pcnt == PS_W'(PRESCALE - 1));
  assign w_wrap     = w_tick && (r_cnt == CNT_W'(PERIOD - 1));
  // The first enabled cycle after en was low also counts as a boundary, without a period_start pulse.
  assign w_boundary = w_wrap || (en && !r_en_q);

  // Prescaler and period counter; both held at zero while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
      r_cnt  <= '0;
    end else if (!en) begin
      r_pcnt <= '0;
      r_cnt  <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // Period wrap pulse and enable history for boundary detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period_start <= 1'b0;
      r_en_q         <= 1'b0;
    end else begin
      r_period_start <= w_wrap;
      r_en_q         <= en;
    end
  end

  assign period_start = r_period_start;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .DATA_W      (DATA_W),
      .PERIOD      (PERIOD),
      .DEAD_PERIODS(DEAD_PERIODS),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_en      (en),
      .i_boundary(w_boundary),
      .i_cnt     (r_cnt),
      .i_wr_en   (wr_en[g]),
      .i_wr_data (wr_data[g*DATA_W +: DATA_W]),
      .o_spd     (spd[g]),
      .o_dir     (dir[g]),
      .o_busy    (busy[g]),
      .o_upd_ack (upd_ack[g])
    );
  end

endmodule
